// File: rtl/jk_cmd_driver.sv
// Command stage for a jk_ff: accepts hold/reset/set/toggle commands over
// valid/ready and applies each one as a train of single-cycle j/k pulses.
// After every pulse the flop output on q_fb is checked against the expected
// value. Each command ends with one done pulse, and err reports any mismatch.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// DRIVE | j/k carry the op code for one cycle; pre-edge q is captured
// CHECK | j/k low; q_fb compared with expected; count down remaining
// DONE  | done pulse with accumulated err; back to IDLE next cycle
module jk_cmd_driver #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op;
  logic [CNT_W-1:0] remaining;
  logic             err_acc;
  logic             q_prev;
  logic             expected;
  logic             mismatch;
  logic             accept;
  logic             more;
  logic             load;
  logic [1:0]       jk_src;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // more applications pending once the one being checked is counted
  assign more      = (remaining > CNT_ONE);
  assign load      = accept || ((state == CHECK) && more);
  // on accept the op register is not loaded yet, so take the op from the port
  assign jk_src    = accept ? cmd_op : op;

  // expected q after one application, from the op and the pre-edge q
  always_comb begin
    expected = q_prev;
    case (op)
      2'b00:   expected = q_prev;
      2'b01:   expected = 1'b0;
      2'b10:   expected = 1'b1;
      default: expected = ~q_prev;
    endcase
    mismatch = (state == CHECK) && (q_fb != expected);
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DRIVE;
      DRIVE:   state_nx = CHECK;
      CHECK:   state_nx = more ? DRIVE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // command datapath: op latch, repeat counter, j/k pulses, readback and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      op        <= 2'b00;
      remaining <= '0;
      err_acc   <= 1'b0;
      q_prev    <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      j    <= load & jk_src[1];
      k    <= load & jk_src[0];
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        op        <= cmd_op;
        remaining <= (cmd_cnt == '0) ? CNT_ONE : cmd_cnt;
        err_acc   <= 1'b0;
      end
      if (state == DRIVE) q_prev <= q_fb;
      if (state == CHECK) begin
        remaining <= remaining - CNT_ONE;
        if (mismatch) err_acc <= 1'b1;
        if (!more) begin
          done <= 1'b1;
          err  <= err_acc | mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural jk_ff closing the loop.
module tb_jk_cmd_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_cnt = 4'd0;
  logic       j, k, q_fb, busy, done, err;

  logic       q_ff = 1'b0;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  int errors = 0;
  int checks = 0;
  int seen_done = 0;

  always #5 clk = ~clk;

  // jk flip-flop model
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  assign q_fb = force_en ? force_val : q_ff;

  jk_cmd_driver #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .j(j), .k(k), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with a pending command
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd1;
    cyc();
    chk("rst_c1_jk", {j, k}, 2'b00);
    chk("rst_c1_done", done, 1'b0);
    cyc();
    chk("rst_c2_jk", {j, k}, 2'b00);
    chk("rst_c2_done", done, 1'b0);
    chk("rst_c2_busy", busy, 1'b0);
    chk("rst_c2_q", q_fb, 1'b0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_idle_busy", busy, 1'b0);

    // 2: set, cnt=1, from q=0
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd1;
    cyc();
    cmd_valid = 1'b0;
    chk("set_c1_jk", {j, k}, 2'b10);
    chk("set_c1_ready", cmd_ready, 1'b0);
    cyc();
    chk("set_c2_jk", {j, k}, 2'b00);
    chk("set_c2_q", q_fb, 1'b1);
    chk("set_c2_done", done, 1'b0);
    cyc();
    chk("set_c3_done", done, 1'b1);
    chk("set_c3_err", err, 1'b0);
    chk("set_c3_ready", cmd_ready, 1'b0);
    cyc();
    chk("set_c4_done", done, 1'b0);
    chk("set_c4_ready", cmd_ready, 1'b1);

    // 4: reset op with cnt=0 means one application
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd0;
    cyc();
    cmd_valid = 1'b0;
    chk("rop_c1_jk", {j, k}, 2'b01);
    chk("rop_c1_busy", busy, 1'b1);
    cyc();
    chk("rop_c2_q", q_fb, 1'b0);
    chk("rop_c2_busy", busy, 1'b1);
    chk("rop_c2_done", done, 1'b0);
    cyc();
    chk("rop_c3_done", done, 1'b1);
    chk("rop_c3_err", err, 1'b0);
    chk("rop_c3_busy", busy, 1'b1);
    cyc();
    chk("rop_c4_busy", busy, 1'b0);
    chk("rop_c4_done", done, 1'b0);

    // 3: toggle x3 from q=0
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cnt = 4'd3;
    cyc();
    cmd_valid = 1'b0;
    chk("tog_c1_jk", {j, k}, 2'b11);
    cyc();
    chk("tog_c2_jk", {j, k}, 2'b00);
    chk("tog_c2_q", q_fb, 1'b1);
    cyc();
    chk("tog_c3_jk", {j, k}, 2'b11);
    chk("tog_c3_done", done, 1'b0);
    cyc();
    chk("tog_c4_q", q_fb, 1'b0);
    cyc();
    chk("tog_c5_jk", {j, k}, 2'b11);
    cyc();
    chk("tog_c6_q", q_fb, 1'b1);
    chk("tog_c6_done", done, 1'b0);
    cyc();
    chk("tog_c7_done", done, 1'b1);
    chk("tog_c7_err", err, 1'b0);
    cyc();

    // 5: forced readback, cmd_valid held, cnt changed mid-command
    force_en = 1'b1; force_val = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd2;
    cyc();
    chk("frc_c1_jk", {j, k}, 2'b10);
    cyc();
    cmd_cnt = 4'd1;
    chk("frc_c2_jk", {j, k}, 2'b00);
    cyc();
    chk("frc_c3_jk", {j, k}, 2'b10);
    chk("frc_c3_done", done, 1'b0);
    cyc();
    chk("frc_c4_ready", cmd_ready, 1'b0);
    cyc();
    chk("frc_c5_done", done, 1'b1);
    chk("frc_c5_err", err, 1'b1);
    chk("frc_c5_ready", cmd_ready, 1'b0);
    cyc();
    force_en = 1'b0;
    chk("frc_c6_ready", cmd_ready, 1'b1);
    chk("frc_c6_done", done, 1'b0);
    chk("frc_c6_err", err, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    chk("rel_c1_jk", {j, k}, 2'b10);
    chk("rel_c1_busy", busy, 1'b1);
    cyc();
    chk("rel_c2_q", q_fb, 1'b1);
    cyc();
    chk("rel_c3_done", done, 1'b1);
    chk("rel_c3_err", err, 1'b0);
    cyc();

    // 6: reset in the middle of a toggle x5 (q starts at 1)
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cnt = 4'd5;
    cyc();
    chk("abt_c1_jk", {j, k}, 2'b11);
    cyc();
    chk("abt_c2_q", q_fb, 1'b0);
    cyc();
    chk("abt_c3_jk", {j, k}, 2'b11);
    rst = 1'b0;
    cyc();
    chk("abt_c4_jk", {j, k}, 2'b00);
    chk("abt_c4_busy", busy, 1'b0);
    chk("abt_c4_done", done, 1'b0);
    chk("abt_c4_q", q_fb, 1'b1);
    cyc();
    chk("abt_c5_busy", busy, 1'b0);
    chk("abt_c5_jk", {j, k}, 2'b00);
    rst = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("abt_acc_busy", busy, 1'b1);
    chk("abt_acc_jk", {j, k}, 2'b11);
    for (int i = 0; i < 20 && seen_done == 0; i++) begin
      cyc();
      if (done === 1'b1) begin
        seen_done = i + 2;
        chk("abt_fin_err", err, 1'b0);
        chk("abt_fin_q", q_fb, 1'b0);
      end
    end
    chk("abt_fin_cycle", seen_done[3:0], 4'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
